boot_image_sender: RTL

- Host-side counterpart of the CPU UART bootloader: streams a 64×16-bit program image over `tx` in the byte format the bootloader expects.
- Optionally reads back the bootloader's memory-scan dump on `rx` and compares it word-by-word against the image.
- Used in FPGA test harnesses and as the bench driver that loads the CPU before release from boot.
- Reads the image from an external combinational ROM/array port.

---
 rtl/boot_image_sender.sv | 253 +++++++++++++++++++++++++
 1 files changed

// File: rtl/boot_image_sender.sv
// boot_image_sender: streams a WORDS x 16-bit image over 8N1 UART (high byte
// first) to the CPU bootloader, and optionally verifies the echoed dump.
// Optional feature macro: BOOT_SENDER_VERIFY_EN (rx receiver + compare).
// Ports: clk; rst (async, active high); ce (clock enable); start;
//   img_adr/img_data (combinational image ROM); tx/rx (UART lines);
//   busy, done, error, err_adr (status, error only with verify).
module boot_image_sender #(
    parameter int CLKS_PER_BIT = 868,
    parameter int WORDS        = 64,
    parameter int ADR_W        = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic             start,
    output logic [ADR_W-1:0] img_adr,
    input  logic [15:0]      img_data,
    output logic             tx,
    input  logic             rx,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [ADR_W-1:0] err_adr
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]    CNT_MAX  = CW'(CLKS_PER_BIT - 1);
    localparam logic [ADR_W-1:0] ADR_LAST = ADR_W'(WORDS - 1);

    typedef enum logic [3:0] {
        IDLE, LOAD, TX_HI, TX_LO, NEXT, RX_HI, RX_LO, CMP, DONE
    } state_t;

    state_t           state_q, state_d;
    logic [ADR_W-1:0] adr_q, adr_d;
    logic [15:0]      hold_q, hold_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [3:0]       bit_q, bit_d;
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             cnt_last;
    logic [3:0]       nxt_bit;
    logic [7:0]       tx_byte;

`ifdef BOOT_SENDER_VERIFY_EN
    localparam logic [CW-1:0] CNT_MID = CW'(CLKS_PER_BIT / 2);
    logic             rx_s1_q, rx_s2_q, rx_prev_q;
    logic             act_q, act_d;
    logic [7:0]       rsh_q, rsh_d;
    logic [7:0]       rhi_q, rhi_d;
    logic             ferr_q, ferr_d;
    logic             err_q, err_d;
    logic [ADR_W-1:0] eadr_q, eadr_d;
`endif

    always_comb begin
        state_d  = state_q;
        adr_d    = adr_q;
        hold_d   = hold_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        tx_d     = tx_q;
        busy_d   = busy_q;
        done_d   = done_q;
        cnt_last = (cnt_q == CNT_MAX);
        nxt_bit  = bit_q + 4'd1;
        tx_byte  = (state_q == TX_HI) ? hold_q[15:8] : hold_q[7:0];
`ifdef BOOT_SENDER_VERIFY_EN
        act_d    = act_q;
        rsh_d    = rsh_q;
        rhi_d    = rhi_q;
        ferr_d   = ferr_q;
        err_d    = err_q;
        eadr_d   = eadr_q;
`endif
        if (ce) begin
            unique case (state_q)
                IDLE: begin
                    tx_d  = 1'b1;
                    adr_d = '0;
                    if (start) begin
                        busy_d  = 1'b1;
                        done_d  = 1'b0;
`ifdef BOOT_SENDER_VERIFY_EN
                        err_d   = 1'b0;
                        eadr_d  = '0;
`endif
                        state_d = LOAD;
                    end
                end
                LOAD: begin
                    hold_d  = img_data;
                    tx_d    = 1'b0;
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = TX_HI;
                end
                TX_HI, TX_LO: begin
                    if (!cnt_last) begin
                        cnt_d = cnt_q + 1'b1;
                    end else begin
                        cnt_d = '0;
                        if (bit_q == 4'd9) begin
                            bit_d = '0;
                            if (state_q == TX_HI) begin
                                // Low byte start bit follows the stop bit directly.
                                tx_d    = 1'b0;
                                state_d = TX_LO;
                            end else begin
                                // tx stays at the stop level through NEXT/LOAD.
                                state_d = NEXT;
                            end
                        end else begin
                            bit_d = nxt_bit;
                            tx_d  = (bit_q == 4'd8) ? 1'b1 : tx_byte[bit_q[2:0]];
                        end
                    end
                end
                NEXT: begin
                    if (adr_q == ADR_LAST) begin
`ifdef BOOT_SENDER_VERIFY_EN
                        adr_d   = '0;
                        act_d   = 1'b0;
                        ferr_d  = 1'b0;
                        state_d = RX_HI;
`else
                        state_d = DONE;
`endif
                    end else begin
                        adr_d   = adr_q + 1'b1;
                        state_d = LOAD;
                    end
                end
`ifdef BOOT_SENDER_VERIFY_EN
                RX_HI, RX_LO: begin
                    if (!act_q) begin
                        // The edge-detect cycle already counts as bit phase 1.
                        if (!rx_s2_q && rx_prev_q) begin
                            act_d = 1'b1;
                            cnt_d = CW'(1);
                            bit_d = '0;
                        end
                    end else begin
                        cnt_d = cnt_last ? '0 : cnt_q + 1'b1;
                        if (cnt_last) begin
                            bit_d = nxt_bit;
                        end
                        if (cnt_q == CNT_MID) begin
                            if (bit_q == 4'd9) begin
                                // Finish at mid stop bit so the next start edge is seen.
                                act_d = 1'b0;
                                if (!rx_s2_q) begin
                                    ferr_d = 1'b1;
                                end
                                if (state_q == RX_HI) begin
                                    rhi_d   = rsh_q;
                                    state_d = RX_LO;
                                end else begin
                                    state_d = CMP;
                                end
                            end else if (bit_q != 4'd0) begin
                                rsh_d = {rx_s2_q, rsh_q[7:1]};
                            end
                        end
                    end
                end
                CMP: begin
                    if ((({rhi_q, rsh_q} != img_data) || ferr_q) && !err_q) begin
                        err_d  = 1'b1;
                        eadr_d = adr_q;
                    end
                    ferr_d = 1'b0;
                    if (adr_q == ADR_LAST) begin
                        state_d = DONE;
                    end else begin
                        adr_d   = adr_q + 1'b1;
                        state_d = RX_HI;
                    end
                end
`endif
                DONE: begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    adr_d   = '0;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            adr_q     <= '0;
            hold_q    <= '0;
            cnt_q     <= '0;
            bit_q     <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef BOOT_SENDER_VERIFY_EN
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
            act_q     <= 1'b0;
            rsh_q     <= '0;
            rhi_q     <= '0;
            ferr_q    <= 1'b0;
            err_q     <= 1'b0;
            eadr_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            adr_q     <= adr_d;
            hold_q    <= hold_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef BOOT_SENDER_VERIFY_EN
            if (ce) begin
                rx_s1_q   <= rx;
                rx_s2_q   <= rx_s1_q;
                rx_prev_q <= rx_s2_q;
            end
            act_q     <= act_d;
            rsh_q     <= rsh_d;
            rhi_q     <= rhi_d;
            ferr_q    <= ferr_d;
            err_q     <= err_d;
            eadr_q    <= eadr_d;
`endif
        end
    end

    assign img_adr = adr_q;
    assign tx      = tx_q;
    assign busy    = busy_q;
    assign done    = done_q;

`ifdef BOOT_SENDER_VERIFY_EN
    assign error   = err_q;
    assign err_adr = eadr_q;
`else
    logic unused_rx;
    assign unused_rx = rx;
    assign error     = 1'b0;
    assign err_adr   = '0;
`endif

endmodule
